// File: rtl/nts_tx_buffer_pkg.sv
// nts_tx_buffer_pkg
// Shared definitions for the NTS transmit buffer: write-port word size
// encodings, the controller state enum and a helper that turns a word size
// into a byte count.
// Build option: NTS_TX_BUFFER_CLEAR_EN adds the ST_CLEAR state.
package nts_tx_buffer_pkg;

  localparam logic [2:0] WS_8  = 3'd0;
  localparam logic [2:0] WS_16 = 3'd1;
  localparam logic [2:0] WS_32 = 3'd2;
  localparam logic [2:0] WS_64 = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_LO   = 3'd1,
    ST_RD_HI   = 3'd2,
    ST_WR_LO   = 3'd3,
    ST_WR_HI   = 3'd4,
    ST_TX_RD   = 3'd5,
    ST_TX_PUSH = 3'd6
`ifdef NTS_TX_BUFFER_CLEAR_EN
    , ST_CLEAR = 3'd7
`endif
  } state_t;

  // Encodings 4..7 behave like a 64-bit access.
  function automatic logic [3:0] ws_bytes(input logic [2:0] ws);
    logic [3:0] n;
    case (ws)
      WS_8:    n = 4'd1;
      WS_16:   n = 4'd2;
      WS_32:   n = 4'd4;
      WS_64:   n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/nts_tx_buffer_ram.sv
// nts_tx_buffer_ram
// Single-port synchronous 64-bit word RAM, depth 2^ADDR_WIDTH, one read or
// one write per cycle. Read data appears the cycle after the request and is
// held until the next read. Contents are not reset.
// Ports: clk_i, en_i (port active), we_i (write when active), addr_i,
//        wdata_i, rdata_o.
module nts_tx_buffer_ram #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [63:0]           wdata_i,
  output logic [63:0]           rdata_o
);

  logic [63:0] mem_q [2**ADDR_WIDTH];
  logic [63:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/nts_tx_buffer.sv
// nts_tx_buffer
// Transmit packet buffer. A byte-addressed big-endian write port
// (8/16/32/64 bit, any alignment) fills a 64-bit word RAM; a transmit
// command streams ceil(len/8) words from word 0 into the TX FIFO.
// Ports: i_clk, i_areset (async, active-high); o_busy; write port
// i_access_port_{addr,wordsize,wr_en,wr_data} with o_access_port_wait;
// i_tx_start/i_tx_length; FIFO side o_tx_fifo_{wr_en,wr_data,last,
// last_bytes} with i_tx_fifo_full; i_clear; o_dbg_state (controller state).
// Build option: NTS_TX_BUFFER_CLEAR_EN enables the zero-fill on i_clear.
// FIFO handshake: a word transfers in every cycle where o_tx_fifo_wr_en is
// high; o_tx_fifo_wr_en is never high while i_tx_fifo_full is high, and the
// presented word/last/last_bytes stay stable until the transfer happens.
module nts_tx_buffer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  output logic                  o_busy,
  output logic                  o_access_port_wait,
  input  logic [ADDR_WIDTH+2:0] i_access_port_addr,
  input  logic [2:0]            i_access_port_wordsize,
  input  logic                  i_access_port_wr_en,
  input  logic [63:0]           i_access_port_wr_data,
  input  logic                  i_tx_start,
  input  logic [ADDR_WIDTH+3:0] i_tx_length,
  output logic                  o_tx_fifo_wr_en,
  output logic [63:0]           o_tx_fifo_wr_data,
  output logic                  o_tx_fifo_last,
  output logic [3:0]            o_tx_fifo_last_bytes,
  input  logic                  i_tx_fifo_full,
  input  logic                  i_clear,
  output logic [2:0]            o_dbg_state
);
  import nts_tx_buffer_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int LW = ADDR_WIDTH + 4;
  localparam logic [LW-1:0] CAP_BYTES = LW'(8 << ADDR_WIDTH);

  state_t state_q, state_d;
  // RAM port is driven from registers: a request decided in one cycle is
  // executed by the RAM in the next, so RMW reads and writes never collide.
  logic          ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [63:0]   ram_wdata_q, ram_wdata_d, ram_rdata;
  logic [AW-1:0] op_word_q, op_word_d;
  logic          op_span_q, op_span_d;
  logic [127:0]  op_data_q, op_data_d;
  logic [15:0]   op_mask_q, op_mask_d;
  logic [63:0]   lo_q, lo_d, hi_q, hi_d;
  logic          rmw_pend_q, rmw_pend_d, zlen_q, zlen_d;
  logic [AW-1:0] tx_idx_q, tx_idx_d, tx_last_q, tx_last_d;
  logic [3:0]    tx_lb_q, tx_lb_d;
`ifdef NTS_TX_BUFFER_CLEAR_EN
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // Write access placed into a 16-byte window (two words), byte 0 = MSB.
  logic [2:0]   wr_off;
  logic [3:0]   wr_n;
  logic [4:0]   wr_shift;
  logic [16:0]  wr_ones;
  logic [15:0]  wr_mask;
  logic [127:0] wr_wide;
  logic         wr_span, wr_aligned;
  assign wr_off     = i_access_port_addr[2:0];
  assign wr_n       = ws_bytes(i_access_port_wordsize);
  assign wr_shift   = 5'd16 - {2'b00, wr_off} - {1'b0, wr_n};
  assign wr_ones    = (17'd1 << wr_n) - 17'd1;
  assign wr_mask    = wr_ones[15:0] << wr_shift;
  assign wr_wide    = {64'd0, i_access_port_wr_data} << {wr_shift, 3'b000};
  assign wr_span    = ({1'b0, wr_off} + wr_n) > 4'd8;
  assign wr_aligned = (wr_off == 3'd0) && (wr_n == 4'd8);

  logic [LW-1:0] len_cl, len_m1;
  assign len_cl = (i_tx_length > CAP_BYTES) ? CAP_BYTES : i_tx_length;
  assign len_m1 = len_cl - LW'(1);

  logic unused_ok;
  assign unused_ok = ^{i_clear, wr_ones[16], len_m1[2:0], len_m1[LW-1]};

  function automatic logic [63:0] merge_word(input logic [63:0] old_w,
                                             input logic [63:0] new_w,
                                             input logic [7:0]  m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = m[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  nts_tx_buffer_ram #(.ADDR_WIDTH(AW)) u_ram (
    .clk_i  (i_clk),
    .en_i   (ram_en_q),
    .we_i   (ram_we_q),
    .addr_i (ram_addr_q),
    .wdata_i(ram_wdata_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q <= ST_IDLE;
      ram_en_q <= 1'b0; ram_we_q <= 1'b0; ram_addr_q <= '0; ram_wdata_q <= '0;
      op_word_q <= '0; op_span_q <= 1'b0; op_data_q <= '0; op_mask_q <= '0;
      lo_q <= '0; hi_q <= '0; rmw_pend_q <= 1'b0; zlen_q <= 1'b0;
      tx_idx_q <= '0; tx_last_q <= '0; tx_lb_q <= '0;
`ifdef NTS_TX_BUFFER_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ram_en_q <= ram_en_d; ram_we_q <= ram_we_d;
      ram_addr_q <= ram_addr_d; ram_wdata_q <= ram_wdata_d;
      op_word_q <= op_word_d; op_span_q <= op_span_d;
      op_data_q <= op_data_d; op_mask_q <= op_mask_d;
      lo_q <= lo_d; hi_q <= hi_d; rmw_pend_q <= rmw_pend_d; zlen_q <= zlen_d;
      tx_idx_q <= tx_idx_d; tx_last_q <= tx_last_d; tx_lb_q <= tx_lb_d;
`ifdef NTS_TX_BUFFER_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ram_en_d = 1'b0; ram_we_d = 1'b0;
    ram_addr_d = ram_addr_q; ram_wdata_d = ram_wdata_q;
    op_word_d = op_word_q; op_span_d = op_span_q;
    op_data_d = op_data_q; op_mask_d = op_mask_q;
    lo_d = lo_q; hi_d = hi_q; rmw_pend_d = 1'b0; zlen_d = 1'b0;
    tx_idx_d = tx_idx_q; tx_last_d = tx_last_q; tx_lb_d = tx_lb_q;
`ifdef NTS_TX_BUFFER_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Start wins over a same-cycle write, which is dropped.
        if (i_tx_start) begin
          if (i_tx_length != '0) begin
            tx_idx_d   = '0;
            tx_last_d  = len_m1[AW+2:3];
            tx_lb_d    = (len_cl[2:0] == 3'd0) ? 4'd8 : {1'b0, len_cl[2:0]};
            ram_en_d   = 1'b1;
            ram_addr_d = '0;
            state_d    = ST_TX_RD;
          end else begin
            zlen_d = 1'b1;
          end
        end
`ifdef NTS_TX_BUFFER_CLEAR_EN
        else if (i_clear) begin
          ram_en_d = 1'b1; ram_we_d = 1'b1; ram_addr_d = '0; ram_wdata_d = '0;
          clr_cnt_d = AW'(1);
          state_d   = ST_CLEAR;
        end
`endif
        else if (i_access_port_wr_en && !rmw_pend_q) begin
          if (wr_aligned) begin
            ram_en_d = 1'b1; ram_we_d = 1'b1;
            ram_addr_d  = i_access_port_addr[AW+2:3];
            ram_wdata_d = i_access_port_wr_data;
          end else begin
            op_word_d  = i_access_port_addr[AW+2:3];
            op_span_d  = wr_span;
            op_data_d  = wr_wide;
            op_mask_d  = wr_mask;
            ram_en_d   = 1'b1;
            ram_addr_d = i_access_port_addr[AW+2:3];
            state_d    = ST_RD_LO;
          end
        end
      end
      ST_RD_LO: begin
        if (op_span_q) begin
          ram_en_d   = 1'b1;
          ram_addr_d = op_word_q + AW'(1);  // wraps to word 0 at the top
        end
        state_d = op_span_q ? ST_RD_HI : ST_WR_LO;
      end
      ST_RD_HI: begin
        lo_d    = ram_rdata;
        state_d = ST_WR_LO;
      end
      ST_WR_LO: begin
        // Spanning: low word was captured earlier, ram_rdata is now the high word.
        hi_d = ram_rdata;
        ram_en_d = 1'b1; ram_we_d = 1'b1; ram_addr_d = op_word_q;
        ram_wdata_d = merge_word(op_span_q ? lo_q : ram_rdata, op_data_q[127:64], op_mask_q[15:8]);
        if (op_span_q) state_d = ST_WR_HI;
        else begin
          state_d    = ST_IDLE;
          rmw_pend_d = 1'b1;
        end
      end
      ST_WR_HI: begin
        ram_en_d = 1'b1; ram_we_d = 1'b1; ram_addr_d = op_word_q + AW'(1);
        ram_wdata_d = merge_word(hi_q, op_data_q[63:0], op_mask_q[7:0]);
        state_d    = ST_IDLE;
        rmw_pend_d = 1'b1;
      end
      ST_TX_RD: state_d = ST_TX_PUSH;
      ST_TX_PUSH: begin
        if (!i_tx_fifo_full) begin
          if (tx_idx_q == tx_last_q) state_d = ST_IDLE;
          else begin
            tx_idx_d   = tx_idx_q + AW'(1);
            ram_en_d   = 1'b1;
            ram_addr_d = tx_idx_q + AW'(1);
            state_d    = ST_TX_RD;
          end
        end
      end
`ifdef NTS_TX_BUFFER_CLEAR_EN
      ST_CLEAR: begin
        // Counter wraps to zero once the last word has been requested.
        if (clr_cnt_q == '0) state_d = ST_IDLE;
        else begin
          ram_en_d = 1'b1; ram_we_d = 1'b1; ram_addr_d = clr_cnt_q; ram_wdata_d = '0;
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  logic tx_push, tx_is_last;
  assign tx_push    = (state_q == ST_TX_PUSH);
  assign tx_is_last = tx_push && (tx_idx_q == tx_last_q);

  // The final RMW write executes in the IDLE cycle after WR_LO/WR_HI.
  assign o_access_port_wait   = (state_q != ST_IDLE) || rmw_pend_q;
  assign o_busy               = (state_q != ST_IDLE) || rmw_pend_q || zlen_q;
  assign o_tx_fifo_wr_en      = tx_push && !i_tx_fifo_full;
  assign o_tx_fifo_wr_data    = tx_push ? ram_rdata : 64'd0;
  assign o_tx_fifo_last       = tx_is_last;
  assign o_tx_fifo_last_bytes = tx_is_last ? tx_lb_q : 4'd0;
  assign o_dbg_state          = state_q;

endmodule

// File: tb/tb_nts_tx_buffer.sv
module tb_nts_tx_buffer;
  localparam int AW  = 8;
  localparam int CAP = 8 << AW;
  localparam int LW  = AW + 4;

  logic          i_clk = 1'b0;
  logic          i_areset;
  logic          o_busy, o_access_port_wait;
  logic [AW+2:0] i_access_port_addr;
  logic [2:0]    i_access_port_wordsize;
  logic          i_access_port_wr_en;
  logic [63:0]   i_access_port_wr_data;
  logic          i_tx_start;
  logic [LW-1:0] i_tx_length;
  logic          o_tx_fifo_wr_en;
  logic [63:0]   o_tx_fifo_wr_data;
  logic          o_tx_fifo_last;
  logic [3:0]    o_tx_fifo_last_bytes;
  logic          i_tx_fifo_full;
  logic          i_clear;
  logic [2:0]    o_dbg_state;

  // clock / reset
  always #5 i_clk = ~i_clk;

  nts_tx_buffer #(.ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_areset(i_areset), .o_busy(o_busy),
    .o_access_port_wait(o_access_port_wait),
    .i_access_port_addr(i_access_port_addr),
    .i_access_port_wordsize(i_access_port_wordsize),
    .i_access_port_wr_en(i_access_port_wr_en),
    .i_access_port_wr_data(i_access_port_wr_data),
    .i_tx_start(i_tx_start), .i_tx_length(i_tx_length),
    .o_tx_fifo_wr_en(o_tx_fifo_wr_en), .o_tx_fifo_wr_data(o_tx_fifo_wr_data),
    .o_tx_fifo_last(o_tx_fifo_last), .o_tx_fifo_last_bytes(o_tx_fifo_last_bytes),
    .i_tx_fifo_full(i_tx_fifo_full), .i_clear(i_clear), .o_dbg_state(o_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [63:0] exp_q[$];
  logic [4:0]  exp_last_q[$];   // {last, last_bytes}
  logic [7:0]  mem_m [CAP];     // byte-level model of the packet RAM

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ws_n(input int ws);
    return (ws >= 3) ? 8 : (1 << ws);
  endfunction

  // driver: one write access, then check how long the port stalls
  task automatic wr(input int a, input int ws, input logic [63:0] d);
    int n, exp_wait, wcnt;
    n = ws_n(ws);
    if ((a % 8) == 0 && n == 8) exp_wait = 0;
    else if (((a % 8) + n) > 8) exp_wait = 5;
    else exp_wait = 3;
    i_access_port_addr     = (AW+3)'(a);
    i_access_port_wordsize = 3'(ws);
    i_access_port_wr_data  = d;
    i_access_port_wr_en    = 1'b1;
    @(negedge i_clk);
    i_access_port_wr_en = 1'b0;
    wcnt = 0;
    while (o_access_port_wait && wcnt < 20) begin
      wcnt++;
      @(negedge i_clk);
    end
    check("wait_cycles", wcnt, exp_wait);
    for (int i = 0; i < n; i++) mem_m[(a + i) % CAP] = d[8*(n-1-i) +: 8];
  endtask

  task automatic expect_tx(input int len);
    int l, nw, lb;
    logic [63:0] w;
    l  = (len > CAP) ? CAP : len;
    nw = (l + 7) / 8;
    lb = (l % 8 == 0) ? 8 : l % 8;
    for (int i = 0; i < nw; i++) begin
      for (int k = 0; k < 8; k++) w[63-8*k -: 8] = mem_m[8*i + k];
      exp_q.push_back(w);
      exp_last_q.push_back((i == nw - 1) ? {1'b1, 4'(lb)} : 5'd0);
    end
  endtask

  // driver + monitor for one transmit.
  // mode 0: never full, 1: random full, 2: full for 3 cycles on word 2.
  // poke: a second start and a write are issued mid-transmit (both ignored).
  task automatic run_tx(input int len, input int mode, input bit poke);
    int cyc, pushes, bp_start;
    bit done;
    logic [4:0] e;
    expect_tx(len);
    i_tx_length = LW'(len);
    i_tx_start  = 1'b1;
    @(negedge i_clk);
    i_tx_start = 1'b0;
    cyc = 0; pushes = 0; bp_start = -1; done = 1'b0;
    while (!done && cyc < 3000) begin
      @(posedge i_clk);
      #1;
      case (mode)
        1:       i_tx_fifo_full = ($urandom_range(0, 3) == 0);
        2:       i_tx_fifo_full = (bp_start >= 0 && cyc >= bp_start && cyc < bp_start + 3);
        default: i_tx_fifo_full = 1'b0;
      endcase
      @(negedge i_clk);
      if (mode == 2 && i_tx_fifo_full && exp_q.size() > 0)
        check("bp_hold_data", o_tx_fifo_wr_data, exp_q[0]);
      if (o_tx_fifo_wr_en) begin
        pushes++;
        check("push_while_full", i_tx_fifo_full, 1'b0);
        if (exp_q.size() == 0) check("extra_push", 1, 0);
        else begin
          check("tx_data", o_tx_fifo_wr_data, exp_q.pop_front());
          e = exp_last_q.pop_front();
          check("tx_last", o_tx_fifo_last, e[4]);
          if (e[4]) check("tx_last_bytes", o_tx_fifo_last_bytes, e[3:0]);
        end
        if (mode == 2 && pushes == 1) bp_start = cyc + 2;
      end
      if (poke && cyc == 2) begin
        i_tx_length = LW'(8); i_tx_start = 1'b1;
        i_access_port_addr = '0; i_access_port_wordsize = 3'd3;
        i_access_port_wr_data = {$urandom, $urandom}; i_access_port_wr_en = 1'b1;
        check("wait_during_tx", o_access_port_wait, 1'b1);
      end else if (poke && cyc == 3) begin
        i_tx_start = 1'b0; i_access_port_wr_en = 1'b0;
      end
      if (!o_busy && cyc > 3) done = 1'b1;
      cyc++;
    end
    i_tx_fifo_full = 1'b0;
    check("tx_done", done, 1'b1);
    check("tx_words_left", exp_q.size(), 0);
    exp_q.delete(); exp_last_q.delete();
  endtask

  initial begin
    int cnt;
    i_areset = 1'b1;
    i_access_port_addr = '0; i_access_port_wordsize = '0;
    i_access_port_wr_en = 1'b0; i_access_port_wr_data = '0;
    i_tx_start = 1'b0; i_tx_length = '0; i_tx_fifo_full = 1'b0; i_clear = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_wait", o_access_port_wait, 0);
    check("rst_wr_en", o_tx_fifo_wr_en, 0);
    check("rst_data", o_tx_fifo_wr_data, 0);
    check("rst_last", {o_tx_fifo_last, o_tx_fifo_last_bytes}, 0);
    i_areset = 1'b0;
    @(negedge i_clk);

    // known contents everywhere
    for (int w = 0; w < CAP / 8; w++) wr(8 * w, 3, {$urandom, $urandom});

    wr(0, 3, 64'hdeadbeef00000000);
    wr(8, 3, 64'habad1deac0fef00d);
    wr(16, 3, 64'h0123456789abcdef);
    run_tx(24, 0, 0);

    wr(6, 2, 64'h11223344);
    run_tx(16, 0, 0);

    wr(23, 0, 64'haa);
    wr(0, 1, 64'hbeef);
    run_tx(13, 0, 0);

    run_tx(24, 2, 0);
    run_tx(24, 0, 1);

    // zero length
    i_tx_length = '0; i_tx_start = 1'b1;
    @(negedge i_clk);
    i_tx_start = 1'b0;
    check("zlen_busy_pulse", o_busy, 1);
    check("zlen_no_push", o_tx_fifo_wr_en, 0);
    @(negedge i_clk);
    check("zlen_busy_end", o_busy, 0);
    check("zlen_no_push2", o_tx_fifo_wr_en, 0);

    // wrap of the last byte into word 0, then an over-capacity length
    wr(CAP - 1, 1, 64'h5a6b);
    run_tx(8, 0, 0);
    run_tx(3000, 1, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 30; i++)
        wr($urandom_range(0, CAP - 1), $urandom_range(0, 7), {$urandom, $urandom});
      run_tx($urandom_range(1, 400), 1, 0);
    end

    // reset in the middle of a transmit
    i_tx_length = LW'(200); i_tx_start = 1'b1;
    @(negedge i_clk);
    i_tx_start = 1'b0;
    cnt = 0;
    while (!o_tx_fifo_wr_en && cnt < 20) begin
      cnt++;
      @(negedge i_clk);
    end
    check("rst_mid_found_push", o_tx_fifo_wr_en, 1);
    #1 i_areset = 1'b1;
    #1;
    check("rst_mid_wr_en", o_tx_fifo_wr_en, 0);
    check("rst_mid_busy", o_busy, 0);
    @(negedge i_clk);
    check("rst_mid_wr_en_next", o_tx_fifo_wr_en, 0);
    i_areset = 1'b0;
    @(negedge i_clk);
    run_tx(40, 1, 0);

`ifdef NTS_TX_BUFFER_CLEAR_EN
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    cnt = 0;
    while (o_busy && cnt < 400) begin
      cnt++;
      @(negedge i_clk);
    end
    check("clear_busy_cycles", cnt, 256);
    for (int i = 0; i < CAP; i++) mem_m[i] = 8'h00;
    run_tx(8, 0, 0);
`else
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    check("clear_ignored", o_busy, 0);
    run_tx(8, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
